// File: rtl/aes_axil_slave_regs.sv
// -----------------------------------------------------------------------------
// aes_axil_slave_regs
//
// AXI4-Lite responder register file sitting in front of an AES-128 ECB core.
// The system master loads the key and plaintext and kicks the core with a
// START write. It then polls STATUS and reads the ciphertext back. Transfers
// are single-beat, 32-bit wide, with at most one write and one read in flight.
//
// Register map (word index = ADDR[5:2], ADDR[1:0] ignored):
//   0x00-0x0C KEY0-3  RW   (KEY0 drives aes_key[127:96])
//   0x10-0x1C PT0-3   RW   (PT0 drives aes_pt[127:96])
//   0x20      CTRL    bit0 START, write-1, reads 0
//   0x24      STATUS  bit0 BUSY (RO), bit1 DONE (sticky, write-1-to-clear)
//   0x28-0x34 CT0-3   RO   (captured from aes_ct on aes_done)
//   0x38-0x3C unmapped -> SLVERR, reads return 0
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   S_AXI_AW* / W* / B*   write address, write data, write response channels
//   S_AXI_AR* / R*        read address and read data channels
//   aes_key, aes_pt       128-bit key and plaintext presented to the core
//   aes_start             one-cycle start pulse to the core
//   aes_ct, aes_done      ciphertext and one-cycle completion pulse from core
// -----------------------------------------------------------------------------
module aes_axil_slave_regs #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]              S_AXI_AWPROT,
  input  logic                    S_AXI_AWVALID,
  output logic                    S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                    S_AXI_WVALID,
  output logic                    S_AXI_WREADY,
  output logic [1:0]              S_AXI_BRESP,
  output logic                    S_AXI_BVALID,
  input  logic                    S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]              S_AXI_ARPROT,
  input  logic                    S_AXI_ARVALID,
  output logic                    S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]              S_AXI_RRESP,
  output logic                    S_AXI_RVALID,
  input  logic                    S_AXI_RREADY,
  output logic [127:0]            aes_key,
  output logic [127:0]            aes_pt,
  output logic                    aes_start,
  input  logic [127:0]            aes_ct,
  input  logic                    aes_done
);

  localparam int NB = DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [3:0] IDX_CTRL   = 4'd8;
  localparam logic [3:0] IDX_STATUS = 4'd9;
  localparam logic [3:0] IDX_CT3    = 4'd13;

  typedef logic [DATA_WIDTH-1:0] word_t;

  // Byte-lane merge used for the strobed KEY/PT registers.
  function automatic word_t merge_bytes(input word_t old_w, input word_t new_w,
                                        input logic [NB-1:0] strb);
    word_t res;
    res = old_w;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Everything up to CT3 decodes; the last two words of the window do not.
  function automatic logic is_mapped(input logic [3:0] idx);
    return (idx <= IDX_CT3);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // en_q keeps every ready low while reset is asserted and for the first
  // edge after it, so the port never advertises readiness during reset.
  logic        en_q, en_d;

  logic        aw_held_q, aw_held_d;
  logic [3:0]  aw_idx_q, aw_idx_d;
  logic        w_held_q, w_held_d;
  word_t       wdata_q, wdata_d;
  logic [NB-1:0] wstrb_q, wstrb_d;

  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;

  logic        rvalid_q, rvalid_d;
  word_t       rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  word_t       key_q [4];
  word_t       key_d [4];
  word_t       pt_q  [4];
  word_t       pt_d  [4];
  word_t       ct_q  [4];
  word_t       ct_d  [4];

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        start_q, start_d;

  // Read decode signals
  logic [3:0]  rd_idx;
  logic [1:0]  ct_sel;
  word_t       rd_word;
  logic [1:0]  rd_resp;

  logic        wr_go;

  // Protection bits and the byte offset within a word carry no meaning here.
  logic        unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------------------
  // Handshake outputs
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = en_q && !aw_held_q && !bvalid_q;
  assign S_AXI_WREADY  = en_q && !w_held_q  && !bvalid_q;
  assign S_AXI_ARREADY = en_q && !rvalid_q;

  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

  assign aes_key   = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_pt    = {pt_q[0],  pt_q[1],  pt_q[2],  pt_q[3]};
  assign aes_start = start_q;

  // The write is performed one cycle after both halves have been captured.
  assign wr_go = aw_held_q && w_held_q;

  // ---------------------------------------------------------------------------
  // Read mux: always reflects the current register contents, so a read and
  // a write landing on the same edge return the pre-write value.
  // ---------------------------------------------------------------------------
  assign rd_idx = S_AXI_ARADDR[5:2];
  // CT0..CT3 sit at word indices 10..13; adding 2 modulo 4 maps them to 0..3.
  assign ct_sel = rd_idx[1:0] + 2'd2;

  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx[3:2])
      2'b00: rd_word = key_q[rd_idx[1:0]];
      2'b01: rd_word = pt_q[rd_idx[1:0]];
      default: begin
        if (rd_idx == IDX_CTRL) begin
          rd_word = '0;
        end else if (rd_idx == IDX_STATUS) begin
          rd_word = {{(DATA_WIDTH-2){1'b0}}, done_q, busy_q};
        end else if (is_mapped(rd_idx)) begin
          rd_word = ct_q[ct_sel];
        end else begin
          rd_resp = RESP_SLVERR;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    en_d      = 1'b1;
    aw_held_d = aw_held_q;
    aw_idx_d  = aw_idx_q;
    w_held_d  = w_held_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    key_d     = key_q;
    pt_d      = pt_q;
    ct_d      = ct_q;
    busy_d    = busy_q;
    done_d    = done_q;
    start_d   = 1'b0;

    // Address and data phases are captured independently, in any order.
    if (S_AXI_AWVALID && S_AXI_AWREADY) begin
      aw_held_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[5:2];
    end
    if (S_AXI_WVALID && S_AXI_WREADY) begin
      w_held_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end

    if (bvalid_q && S_AXI_BREADY) bvalid_d = 1'b0;

    // Both halves held: commit, free the holding registers, raise BVALID.
    // The holders cannot refill while BVALID is up, so this never collides
    // with the response retirement above.
    if (wr_go) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = is_mapped(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      case (aw_idx_q[3:2])
        // Core inputs are frozen while an encryption is running.
        2'b00: if (!busy_q) key_d[aw_idx_q[1:0]] =
                 merge_bytes(key_q[aw_idx_q[1:0]], wdata_q, wstrb_q);
        2'b01: if (!busy_q) pt_d[aw_idx_q[1:0]] =
                 merge_bytes(pt_q[aw_idx_q[1:0]], wdata_q, wstrb_q);
        default: begin
          if (aw_idx_q == IDX_CTRL && wstrb_q[0] && wdata_q[0] && !busy_q) begin
            start_d = 1'b1;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
          if (aw_idx_q == IDX_STATUS && wstrb_q[0] && wdata_q[1]) begin
            done_d = 1'b0;
          end
        end
      endcase
    end

    // Completion is evaluated after the write so that a coincident
    // DONE-clear loses to the set. A START in the same cycle was already
    // rejected because busy_q is still 1.
    if (aes_done && busy_q) begin
      ct_d[0] = aes_ct[127:96];
      ct_d[1] = aes_ct[95:64];
      ct_d[2] = aes_ct[63:32];
      ct_d[3] = aes_ct[31:0];
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end

    // Read channel: one outstanding read, data registered on acceptance.
    if (S_AXI_ARVALID && S_AXI_ARREADY) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_word;
      rresp_d  = rd_resp;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      en_q      <= 1'b0;
      aw_held_q <= 1'b0;
      aw_idx_q  <= '0;
      w_held_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      key_q     <= '{default: '0};
      pt_q      <= '{default: '0};
      ct_q      <= '{default: '0};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      en_q      <= en_d;
      aw_held_q <= aw_held_d;
      aw_idx_q  <= aw_idx_d;
      w_held_q  <= w_held_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      key_q     <= key_d;
      pt_q      <= pt_d;
      ct_q      <= ct_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
    end
  end

endmodule

// File: tb/tb_aes_axil_slave_regs.sv
// Testbench for aes_axil_slave_regs: directed vector table, hand-written
// multi-cycle sequences, and a randomized phase against a transaction-level
// reference model of the register map.
module tb_aes_axil_slave_regs;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [5:0]   S_AXI_AWADDR;
  logic [2:0]   S_AXI_AWPROT;
  logic         S_AXI_AWVALID;
  logic         S_AXI_AWREADY;
  logic [31:0]  S_AXI_WDATA;
  logic [3:0]   S_AXI_WSTRB;
  logic         S_AXI_WVALID;
  logic         S_AXI_WREADY;
  logic [1:0]   S_AXI_BRESP;
  logic         S_AXI_BVALID;
  logic         S_AXI_BREADY;
  logic [5:0]   S_AXI_ARADDR;
  logic [2:0]   S_AXI_ARPROT;
  logic         S_AXI_ARVALID;
  logic         S_AXI_ARREADY;
  logic [31:0]  S_AXI_RDATA;
  logic [1:0]   S_AXI_RRESP;
  logic         S_AXI_RVALID;
  logic         S_AXI_RREADY;
  logic [127:0] aes_key;
  logic [127:0] aes_pt;
  logic         aes_start;
  logic [127:0] aes_ct;
  logic         aes_done;

  aes_axil_slave_regs #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .aes_key(aes_key), .aes_pt(aes_pt), .aes_start(aes_start),
    .aes_ct(aes_ct), .aes_done(aes_done)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int b_hs = 0;

  // Cycles with aes_start high, and accepted write responses.
  always @(negedge ACLK) begin
    if (aes_start === 1'b1) start_cnt++;
    if (S_AXI_BVALID === 1'b1 && S_AXI_BREADY === 1'b1) b_hs++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string what);
    total++;
    bad++;
    $display("FAIL timeout %s: got no handshake expected one within 50 cycles", what);
  endtask

  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    bit aw_p, w_p, awf, wf;
    @(negedge ACLK);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data;  S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
    aw_p = 1'b1; w_p = 1'b1; n = 0;
    while ((aw_p || w_p) && n < 50) begin
      awf = aw_p && S_AXI_AWREADY;
      wf  = w_p && S_AXI_WREADY;
      @(negedge ACLK);
      if (awf) begin aw_p = 1'b0; S_AXI_AWVALID = 1'b0; end
      if (wf)  begin w_p = 1'b0;  S_AXI_WVALID = 1'b0; end
      n++;
    end
    while (!S_AXI_BVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) begin
      timeout("write");
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      resp = 2'bxx;
    end else begin
      resp = S_AXI_BRESP;
    end
    @(negedge ACLK);
  endtask

  task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int n;
    bit arf;
    @(negedge ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    arf = 1'b0; n = 0;
    while (!arf && n < 50) begin
      arf = S_AXI_ARREADY;
      @(negedge ACLK);
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    while (!S_AXI_RVALID && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) begin
      timeout("read");
      data = 'x; resp = 2'bxx;
    end else begin
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
    end
    @(negedge ACLK);
  endtask

  task automatic pulse_done(input logic [127:0] ct);
    @(negedge ACLK);
    aes_done = 1'b1; aes_ct = ct;
    @(negedge ACLK);
    aes_done = 1'b0;
  endtask

  // Write whose commit edge coincides with an aes_done pulse.
  task automatic write_with_done(input logic [5:0] addr, input logic [31:0] data,
                                 input logic [127:0] ct, input string name);
    @(negedge ACLK);
    check({name, "_rdy"}, {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    S_AXI_AWADDR = addr; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data;  S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    aes_done = 1'b1; aes_ct = ct;
    @(negedge ACLK);
    aes_done = 1'b0;
    check({name, "_bvalid"}, {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    @(negedge ACLK);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the register map as plain arrays and flags.
  // ---------------------------------------------------------------------------
  logic [31:0] m_key [4];
  logic [31:0] m_pt  [4];
  logic [31:0] m_ct  [4];
  bit          m_busy, m_done;
  int          m_starts;

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin m_key[i] = 0; m_pt[i] = 0; m_ct[i] = 0; end
    m_busy = 0; m_done = 0; m_starts = 0;
  endtask

  function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp);
    resp = (idx >= 14) ? 2'b10 : 2'b00;
    if (idx < 4) begin
      if (!m_busy) m_key[idx] = m_merge(m_key[idx], d, s);
    end else if (idx < 8) begin
      if (!m_busy) m_pt[idx-4] = m_merge(m_pt[idx-4], d, s);
    end else if (idx == 8) begin
      if (s[0] && d[0] && !m_busy) begin m_busy = 1; m_done = 0; m_starts++; end
    end else if (idx == 9) begin
      if (s[0] && d[1]) m_done = 0;
    end
  endtask

  function automatic logic [33:0] m_read(input int idx);
    if (idx < 4)       return {2'b00, m_key[idx]};
    else if (idx < 8)  return {2'b00, m_pt[idx-4]};
    else if (idx == 8) return 34'h0;
    else if (idx == 9) return {2'b00, 30'h0, m_done, m_busy};
    else if (idx < 14) return {2'b00, m_ct[idx-10]};
    else               return {2'b10, 32'h0};
  endfunction

  task automatic m_done_pulse(input logic [127:0] ct);
    if (m_busy) begin
      m_ct[0] = ct[127:96]; m_ct[1] = ct[95:64]; m_ct[2] = ct[63:32]; m_ct[3] = ct[31:0];
      m_busy = 0; m_done = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          is_wr;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit w, input logic [5:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] ed,
                              input logic [1:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    return v;
  endfunction

  initial begin
    logic [31:0]  rd;
    logic [1:0]   rs;
    logic [31:0]  wd;
    logic [3:0]   ws;
    logic [33:0]  ex;
    logic [127:0] ct_a, ct_b;
    int sc0, bh0, idx, op;

    // Write KEY/PT, read back, probe RO/unmapped space, then byte strobes.
    vecs.push_back(mk(1, 6'h00, 32'h00010203, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h04, 32'h04050607, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h08, 32'h08090a0b, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h0C, 32'h0c0d0e0f, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h10, 32'h00112233, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h14, 32'h44556677, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h18, 32'h8899aabb, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h1C, 32'hccddeeff, 4'hf, 0, 2'b00));
    vecs.push_back(mk(0, 6'h00, 0, 0, 32'h00010203, 2'b00));
    vecs.push_back(mk(0, 6'h04, 0, 0, 32'h04050607, 2'b00));
    vecs.push_back(mk(0, 6'h08, 0, 0, 32'h08090a0b, 2'b00));
    vecs.push_back(mk(0, 6'h0C, 0, 0, 32'h0c0d0e0f, 2'b00));
    vecs.push_back(mk(0, 6'h10, 0, 0, 32'h00112233, 2'b00));
    vecs.push_back(mk(0, 6'h14, 0, 0, 32'h44556677, 2'b00));
    vecs.push_back(mk(0, 6'h18, 0, 0, 32'h8899aabb, 2'b00));
    vecs.push_back(mk(0, 6'h1C, 0, 0, 32'hccddeeff, 2'b00));
    vecs.push_back(mk(0, 6'h20, 0, 0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 6'h24, 0, 0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 6'h28, 0, 0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 6'h34, 0, 0, 32'h0, 2'b00));
    vecs.push_back(mk(0, 6'h3C, 0, 0, 32'h0, 2'b10));
    vecs.push_back(mk(1, 6'h38, 32'h12345678, 4'hf, 0, 2'b10));
    vecs.push_back(mk(0, 6'h38, 0, 0, 32'h0, 2'b10));
    vecs.push_back(mk(1, 6'h28, 32'hffffffff, 4'hf, 0, 2'b00));
    vecs.push_back(mk(0, 6'h28, 0, 0, 32'h0, 2'b00));
    vecs.push_back(mk(1, 6'h10, 32'h00000000, 4'hf, 0, 2'b00));
    vecs.push_back(mk(1, 6'h10, 32'hAABBCCDD, 4'b0101, 0, 2'b00));
    vecs.push_back(mk(0, 6'h10, 0, 0, 32'h00BB00DD, 2'b00));
    vecs.push_back(mk(0, 6'h13, 0, 0, 32'h00BB00DD, 2'b00));
    vecs.push_back(mk(1, 6'h16, 32'h11223344, 4'b1010, 0, 2'b00));
    vecs.push_back(mk(0, 6'h14, 0, 0, 32'h11553377, 2'b00));

    ARESET = 1'b1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0;  S_AXI_WSTRB = 0;  S_AXI_WVALID = 0;
    S_AXI_BREADY = 1'b1;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 1'b1;
    aes_ct = 0; aes_done = 0;

    // ---- reset ----
    repeat (20) begin
      @(negedge ACLK);
      check("reset_handshakes",
            {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, aes_start},
            6'b0);
    end
    check("reset_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 36'h0);
    check("reset_key_pt", {aes_key, aes_pt} >> 128 | aes_pt, 128'h0);
    ARESET = 1'b0;
    @(negedge ACLK);
    @(negedge ACLK);
    check("ready_after_reset", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
    for (int i = 0; i < 14; i++) begin
      axi_read(6'(i * 4), rd, rs);
      check($sformatf("reset_read_%0d", i), {rs, rd}, 34'h0);
    end

    // ---- directed table ----
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, rs);
        check($sformatf("vec%0d_bresp", i), rs, vecs[i].exp_resp);
      end else begin
        axi_read(vecs[i].addr, rd, rs);
        check($sformatf("vec%0d_read", i), {rs, rd}, {vecs[i].exp_resp, vecs[i].exp_data});
      end
    end
    check("aes_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
    check("aes_pt", aes_pt, 128'h00BB00DD115533778899aabbccddeeff);

    // ---- encryption round trip ----
    sc0 = start_cnt;
    axi_write(6'h20, 32'h1, 4'hf, rs);
    check("start_pulse_once", start_cnt - sc0, 1);
    axi_read(6'h24, rd, rs);
    check("status_busy", {rs, rd}, 34'h1);
    check("start_pulse_still_once", start_cnt - sc0, 1);
    ct_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    pulse_done(ct_a);
    axi_read(6'h24, rd, rs);
    check("status_done", {rs, rd}, 34'h2);
    axi_read(6'h28, rd, rs);
    check("ct0", {rs, rd}, {2'b00, 32'h69c4e0d8});
    axi_read(6'h34, rd, rs);
    check("ct3", {rs, rd}, {2'b00, 32'h70b4c55a});
    axi_write(6'h24, 32'h2, 4'hf, rs);
    axi_read(6'h24, rd, rs);
    check("status_cleared", {rs, rd}, 34'h0);

    // ---- W three cycles ahead of AW ----
    bh0 = b_hs;
    @(negedge ACLK);
    S_AXI_WDATA = 32'h12345678; S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    repeat (2) @(negedge ACLK);
    check("w_first_no_bvalid", S_AXI_BVALID, 1'b0);
    S_AXI_AWADDR = 6'h14; S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    repeat (6) @(negedge ACLK);
    check("w_first_one_bresp", b_hs - bh0, 1);
    axi_read(6'h14, rd, rs);
    check("w_first_data", {rs, rd}, {2'b00, 32'h12345678});

    // ---- B channel back-pressure ----
    S_AXI_BREADY = 1'b0;
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h18; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h0badf00d; S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_%0d", i), {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 3'b100);
      @(negedge ACLK);
    end
    S_AXI_BREADY = 1'b1;
    @(negedge ACLK);
    check("bp_release", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);

    // ---- writes while busy ----
    sc0 = start_cnt;
    axi_write(6'h20, 32'h1, 4'hf, rs);
    axi_write(6'h00, 32'hdeadbeef, 4'hf, rs);
    check("busy_key_bresp", rs, 2'b00);
    axi_write(6'h20, 32'h1, 4'hf, rs);
    check("busy_start_bresp", rs, 2'b00);
    check("busy_no_second_start", start_cnt - sc0, 1);
    axi_read(6'h00, rd, rs);
    check("busy_key_kept", {rs, rd}, {2'b00, 32'h00010203});
    check("busy_aes_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);

    // ---- DONE-clear coincident with aes_done: set wins ----
    ct_b = 128'h0123456789abcdeffedcba9876543210;
    write_with_done(6'h24, 32'h2, ct_b, "clr_vs_done");
    axi_read(6'h24, rd, rs);
    check("clr_vs_done_status", {rs, rd}, 34'h2);
    axi_read(6'h28, rd, rs);
    check("clr_vs_done_ct0", {rs, rd}, {2'b00, 32'h01234567});

    // ---- START coincident with aes_done: START ignored ----
    sc0 = start_cnt;
    axi_write(6'h20, 32'h1, 4'hf, rs);
    check("restart_pulse", start_cnt - sc0, 1);
    write_with_done(6'h20, 32'h1, ct_a, "start_vs_done");
    check("start_vs_done_no_pulse", start_cnt - sc0, 1);
    axi_read(6'h24, rd, rs);
    check("start_vs_done_status", {rs, rd}, 34'h2);

    // ---- aes_done while idle is ignored ----
    pulse_done({4{32'hffffffff}});
    axi_read(6'h28, rd, rs);
    check("idle_done_ct0", {rs, rd}, {2'b00, 32'h69c4e0d8});

    // ---- reset in the middle of a write ----
    @(negedge ACLK);
    S_AXI_AWADDR = 6'h04; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h55aa55aa; S_AXI_WSTRB = 4'hf; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    #1 ARESET = 1'b1;
    @(negedge ACLK);
    check("abort_in_reset", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b00);
    ARESET = 1'b0;
    repeat (3) @(negedge ACLK);
    check("abort_no_resp", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 4'b0111);
    axi_read(6'h04, rd, rs);
    check("abort_key1_zero", {rs, rd}, 34'h0);

    // ---- randomized phase against the reference model ----
    m_reset();
    sc0 = start_cnt;
    for (int i = 0; i < 250; i++) begin
      op = $urandom_range(0, 9);
      idx = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 9) : $urandom_range(0, 15);
      if (op < 4) begin
        wd = $urandom;
        if (idx == 8 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
        ws = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) ws[0] = 1'b1;
        axi_write({4'(idx), 2'($urandom_range(0, 3))}, wd, ws, rs);
        m_write(idx, wd, ws, ex[33:32]);
        check($sformatf("rnd%0d_bresp_idx%0d", i, idx), rs, ex[33:32]);
      end else if (op < 8) begin
        axi_read({4'(idx), 2'($urandom_range(0, 3))}, rd, rs);
        ex = m_read(idx);
        check($sformatf("rnd%0d_read_idx%0d", i, idx), {rs, rd}, ex);
      end else begin
        ct_b = {$urandom, $urandom, $urandom, $urandom};
        pulse_done(ct_b);
        m_done_pulse(ct_b);
      end
    end
    check("rnd_start_count", start_cnt - sc0, m_starts);
    check("rnd_aes_key", aes_key, {m_key[0], m_key[1], m_key[2], m_key[3]});
    check("rnd_aes_pt", aes_pt, {m_pt[0], m_pt[1], m_pt[2], m_pt[3]});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
